// File: rtl/ahb_tcm_arb_pkg.sv
// ahb_tcm_arb_pkg: shared AHB-Lite encodings, port state type and byte-lane helper
package ahb_tcm_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [2:0] {IDLE, WAIT, DONE, ERR1, ERR2} port_state_e;

    function automatic logic [3:0] size_to_be(input logic [2:0] hsize, input logic [1:0] addr);
        return hsize == HSIZE_BYTE ? 4'b0001 << addr :
               hsize == HSIZE_HALF ? 4'b0011 << {addr[1], 1'b0} :
               hsize == HSIZE_WORD ? 4'hF : 4'h0;
    endfunction

endpackage

// File: rtl/ahb_tcm_arb_port.sv
// ahb_tcm_arb_port: one AHB-Lite slave port; captures the address phase, checks it and
// holds a RAM request until granted.
module ahb_tcm_arb_port
    import ahb_tcm_arb_pkg::*;
#(
    parameter int RAM_AW = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hsel,
    input  logic [1:0]        htrans,
    input  logic [31:0]       haddr,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [31:0]       ram_rdata,
    input  logic              grant,
    output logic              hready,
    output logic              hresp,
    output logic [31:0]       hrdata,
    output logic              req,
    output logic [RAM_AW-1:0] addr,
    output logic [3:0]        be,
    output logic              write
);

    port_state_e       state;
    logic [RAM_AW+1:0] addr_q;
    logic [2:0]        size_q;
    logic              write_q;
    logic              ready_phase;
    logic              capture;
    logic              err;

    assign ready_phase = state == IDLE || state == DONE || state == ERR2;
    assign capture     = ready_phase && hsel && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    assign err = haddr[31:RAM_AW+2] != '0 || hsize > HSIZE_WORD ||
                 (hsize == HSIZE_HALF && haddr[0]) ||
                 (hsize == HSIZE_WORD && haddr[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            size_q  <= HSIZE_BYTE;
            write_q <= 1'b0;
        end else begin
            if (capture) begin
                addr_q  <= haddr[RAM_AW+1:0];
                size_q  <= hsize;
                write_q <= hwrite;
            end
            state <= capture         ? (err ? ERR1 : WAIT) :
                     state == WAIT   ? (grant ? DONE : WAIT) :
                     state == ERR1   ? ERR2 : IDLE;
        end
    end

    assign hready = state != WAIT && state != ERR1;
    assign hresp  = state == ERR1 || state == ERR2;
    // Read data is only routed while this port holds the completed read.
    assign hrdata = (state == DONE && !write_q) ? ram_rdata : '0;
    assign req    = state == WAIT;
    assign addr   = addr_q[RAM_AW+1:2];
    assign be     = size_to_be(size_q, addr_q[1:0]);
    assign write  = write_q;

endmodule

// File: rtl/ahb_tcm_arbiter.sv
// ahb_tcm_arbiter: shares one single-port synchronous TCM between the SCR1 imem and dmem
// AHB-Lite ports with fixed priority and a starvation guard.
module ahb_tcm_arbiter
    import ahb_tcm_arb_pkg::*;
#(
    parameter int RAM_AW     = 11,
    parameter bit DMEM_PRIO  = 1'b1,
    parameter int MAX_STREAK = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        imem_htrans,
    input  logic [31:0]       imem_haddr,
    input  logic [2:0]        imem_hsize,
    output logic              imem_hready,
    output logic [31:0]       imem_hrdata,
    output logic              imem_hresp,
    input  logic              dmem_hsel,
    input  logic [1:0]        dmem_htrans,
    input  logic [31:0]       dmem_haddr,
    input  logic              dmem_hwrite,
    input  logic [2:0]        dmem_hsize,
    input  logic [31:0]       dmem_hwdata,
    output logic              dmem_hready,
    output logic [31:0]       dmem_hrdata,
    output logic              dmem_hresp,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int SW = $clog2(MAX_STREAK + 2);

    logic              imem_req, dmem_req;
    logic              imem_gnt, dmem_gnt;
    logic              imem_write, dmem_write;
    logic [RAM_AW-1:0] imem_addr, dmem_addr;
    logic [3:0]        imem_be, dmem_be;
    logic              conflict, force_other;
    logic [SW-1:0]     streak;

    ahb_tcm_arb_port #(.RAM_AW(RAM_AW)) u_imem (
        .clk       (clk),
        .rst_n     (rst_n),
        .hsel      (1'b1),
        .htrans    (imem_htrans),
        .haddr     (imem_haddr),
        .hwrite    (1'b0),
        .hsize     (imem_hsize),
        .ram_rdata (ram_rdata),
        .grant     (imem_gnt),
        .hready    (imem_hready),
        .hresp     (imem_hresp),
        .hrdata    (imem_hrdata),
        .req       (imem_req),
        .addr      (imem_addr),
        .be        (imem_be),
        .write     (imem_write)
    );

    ahb_tcm_arb_port #(.RAM_AW(RAM_AW)) u_dmem (
        .clk       (clk),
        .rst_n     (rst_n),
        .hsel      (dmem_hsel),
        .htrans    (dmem_htrans),
        .haddr     (dmem_haddr),
        .hwrite    (dmem_hwrite),
        .hsize     (dmem_hsize),
        .ram_rdata (ram_rdata),
        .grant     (dmem_gnt),
        .hready    (dmem_hready),
        .hresp     (dmem_hresp),
        .hrdata    (dmem_hrdata),
        .req       (dmem_req),
        .addr      (dmem_addr),
        .be        (dmem_be),
        .write     (dmem_write)
    );

    // After MAX_STREAK consecutive conflict wins the waiting port is served next.
    assign conflict    = imem_req && dmem_req;
    assign force_other = streak == SW'(MAX_STREAK);
    assign dmem_gnt    = conflict ? (DMEM_PRIO ^ force_other) : dmem_req;
    assign imem_gnt    = conflict ? !dmem_gnt : imem_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            streak <= '0;
        else
            streak <= (conflict && dmem_gnt == DMEM_PRIO) ? streak + 1'b1 : '0;
    end

    assign ram_en    = imem_gnt || dmem_gnt;
    assign ram_addr  = dmem_gnt ? dmem_addr : imem_addr;
    assign ram_we    = (dmem_gnt && dmem_write) ? dmem_be :
                       (imem_gnt && imem_write) ? imem_be : 4'h0;
    assign ram_wdata = (dmem_gnt && dmem_write) ? dmem_hwdata : '0;

endmodule

// File: tb/tb_ahb_tcm_arbiter.sv
// tb_ahb_tcm_arbiter: directed and randomized checks of the TCM arbiter against a word-array
// memory model and AHB-Lite timing rules.
module tb_ahb_tcm_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  imem_htrans;
    logic [31:0] imem_haddr;
    logic [2:0]  imem_hsize;
    logic        imem_hready;
    logic [31:0] imem_hrdata;
    logic        imem_hresp;
    logic        dmem_hsel;
    logic [1:0]  dmem_htrans;
    logic [31:0] dmem_haddr;
    logic        dmem_hwrite;
    logic [2:0]  dmem_hsize;
    logic [31:0] dmem_hwdata;
    logic        dmem_hready;
    logic [31:0] dmem_hrdata;
    logic        dmem_hresp;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [10:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;

    logic [31:0] mem     [2048];
    logic [31:0] ref_mem [2048];
    logic        load = 1'b0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    ahb_tcm_arbiter #(.RAM_AW(11), .DMEM_PRIO(1'b1), .MAX_STREAK(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_htrans (imem_htrans),
        .imem_haddr  (imem_haddr),
        .imem_hsize  (imem_hsize),
        .imem_hready (imem_hready),
        .imem_hrdata (imem_hrdata),
        .imem_hresp  (imem_hresp),
        .dmem_hsel   (dmem_hsel),
        .dmem_htrans (dmem_htrans),
        .dmem_haddr  (dmem_haddr),
        .dmem_hwrite (dmem_hwrite),
        .dmem_hsize  (dmem_hsize),
        .dmem_hwdata (dmem_hwdata),
        .dmem_hready (dmem_hready),
        .dmem_hrdata (dmem_hrdata),
        .dmem_hresp  (dmem_hresp),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    // Single-port synchronous RAM with byte enables; preloaded from the model image.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 2048; i++) mem[i] <= ref_mem[i];
        end else if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic imem_read_t1(input string p);
        imem_htrans = 2'b10; imem_haddr = 32'h10; imem_hsize = 3'd2;
        @(negedge clk);
        chk({p, "_wait_hready"}, imem_hready, 1'b0);
        chk({p, "_ram_en"}, ram_en, 1'b1);
        chk({p, "_ram_addr"}, ram_addr, 4);
        chk({p, "_ram_we"}, ram_we, 4'h0);
        imem_htrans = 2'b00;
        @(negedge clk);
        chk({p, "_done_hready"}, imem_hready, 1'b1);
        chk({p, "_hresp"}, imem_hresp, 1'b0);
        chk({p, "_hrdata"}, imem_hrdata, 32'h00167613);
        chk({p, "_ram_idle"}, ram_en, 1'b0);
        @(negedge clk);
        chk({p, "_idle_hrdata"}, imem_hrdata, 32'h0);
    endtask

    task automatic imem_master(input int n, input bit stream);
        int issued = 0, done = 0, waits = 0, budget = 0, w = 0;
        bit dv = 0;
        logic [31:0] exp;
        while (done < n) begin
            @(negedge clk);
            if (++budget > 4000) begin
                chk("i_timeout", done, n);
                break;
            end
            if (imem_hready) begin
                if (dv) begin
                    exp = ref_mem[w];
                    chk("i_hrdata", imem_hrdata, exp);
                    chk("i_hresp", imem_hresp, 1'b0);
                    chk("i_wait_bound", waits >= 1 && waits <= 3, 1'b1);
                    done++;
                end
                if (issued < n && (stream || $urandom_range(0, 2) != 0)) begin
                    w = $urandom_range(0, 255);
                    imem_hsize = 3'($urandom_range(0, 2));
                    imem_haddr = 32'(w * 4 + (imem_hsize == 3'd0 ? $urandom_range(0, 3) :
                                              imem_hsize == 3'd1 ? 2 * $urandom_range(0, 1) : 0));
                    imem_htrans = {1'b1, 1'($urandom_range(0, 1))};
                    dv = 1; waits = 0; issued++;
                end else begin
                    imem_htrans = 2'b00;
                    dv = 0;
                end
            end else if (dv) waits++;
        end
        imem_htrans = 2'b00;
    endtask

    task automatic dmem_master(input int n, input bit stream);
        int issued = 0, done = 0, waits = 0, budget = 0, w = 0, o = 0;
        bit dv = 0, dwr = 0, derr = 0;
        logic [31:0] da = 0, dw = 0, exp;
        logic [2:0]  dsz = 0;
        while (done < n) begin
            @(negedge clk);
            if (++budget > 4000) begin
                chk("d_timeout", done, n);
                break;
            end
            if (dmem_hready) begin
                if (dv) begin
                    chk("d_hresp", dmem_hresp, derr);
                    chk("d_wait_bound", waits >= 1 && waits <= (derr ? 1 : 3), 1'b1);
                    if (!derr) begin
                        exp = dwr ? 32'h0 : ref_mem[da[12:2]];
                        chk("d_hrdata", dmem_hrdata, exp);
                        if (dwr)
                            for (int k = 0; k < (1 << dsz); k++) begin
                                o = int'(da[1:0]) + k;
                                ref_mem[da[12:2]][8*o +: 8] = dw[8*o +: 8];
                            end
                    end
                    done++;
                end
                if (issued < n && (stream || $urandom_range(0, 2) != 0)) begin
                    w = 256 + $urandom_range(0, 255);
                    dsz = 3'($urandom_range(0, 2));
                    da = 32'(w * 4 + (dsz == 3'd0 ? $urandom_range(0, 3) :
                                      dsz == 3'd1 ? 2 * $urandom_range(0, 1) : 0));
                    derr = 0;
                    if ($urandom_range(0, 7) == 0) begin
                        derr = 1;
                        case ($urandom_range(0, 2))
                            0: da = da | (32'h2000 << $urandom_range(0, 18));
                            1: begin dsz = 3'd2; da = 32'(w * 4 + $urandom_range(1, 3)); end
                            default: dsz = 3'($urandom_range(3, 7));
                        endcase
                    end
                    dwr = 1'($urandom_range(0, 1));
                    dw = $urandom;
                    dmem_haddr = da; dmem_hsize = dsz; dmem_hwrite = dwr; dmem_hwdata = dw;
                    dmem_htrans = {1'b1, 1'($urandom_range(0, 1))};
                    dv = 1; waits = 0; issued++;
                end else begin
                    dmem_htrans = 2'b00;
                    dv = 0;
                end
            end else if (dv) waits++;
        end
        dmem_htrans = 2'b00;
        dmem_hwrite = 1'b0;
    endtask

    initial begin
        imem_htrans = 2'b00; imem_haddr = '0; imem_hsize = 3'd2;
        dmem_hsel = 1'b1; dmem_htrans = 2'b00; dmem_haddr = '0;
        dmem_hwrite = 1'b0; dmem_hsize = 3'd2; dmem_hwdata = '0;
        for (int i = 0; i < 2048; i++) ref_mem[i] = $urandom;
        ref_mem[4] = 32'h00167613;
        load = 1'b1;
        repeat (2) @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        chk("rst_i_hready", imem_hready, 1'b1);
        chk("rst_d_hready", dmem_hready, 1'b1);
        chk("rst_hresp", {imem_hresp, dmem_hresp}, 2'b00);
        chk("rst_hrdata", imem_hrdata | dmem_hrdata, 32'h0);
        chk("rst_ram", {ram_en, ram_we}, 5'h0);
        rst_n = 1'b1;

        imem_read_t1("t1");

        // Same-cycle conflict: dmem has priority
        imem_htrans = 2'b10; imem_haddr = 32'h0;
        dmem_htrans = 2'b10; dmem_haddr = 32'h8; dmem_hsize = 3'd2;
        @(negedge clk);
        chk("t2_hready_both", {imem_hready, dmem_hready}, 2'b00);
        chk("t2_ram_en1", ram_en, 1'b1);
        chk("t2_ram_addr1", ram_addr, 2);
        imem_htrans = 2'b00; dmem_htrans = 2'b00;
        @(negedge clk);
        chk("t2_d_done", {imem_hready, dmem_hready}, 2'b01);
        chk("t2_d_hrdata", dmem_hrdata, ref_mem[2]);
        chk("t2_i_hrdata_hidden", imem_hrdata, 32'h0);
        chk("t2_ram_en2", ram_en, 1'b1);
        chk("t2_ram_addr2", ram_addr, 0);
        @(negedge clk);
        chk("t2_i_done", imem_hready, 1'b1);
        chk("t2_i_hrdata", imem_hrdata, ref_mem[0]);
        chk("t2_ram_idle", ram_en, 1'b0);

        // Byte write to lane 3, then back-to-back word read
        dmem_htrans = 2'b10; dmem_haddr = 32'h3; dmem_hsize = 3'd0;
        dmem_hwrite = 1'b1; dmem_hwdata = 32'hA500_0000;
        @(negedge clk);
        chk("t3_ram_we", ram_we, 4'b1000);
        chk("t3_ram_wdata", ram_wdata[31:24], 8'hA5);
        chk("t3_hready", dmem_hready, 1'b0);
        dmem_htrans = 2'b00; dmem_hwrite = 1'b0;
        @(negedge clk);
        chk("t3_w_done", {dmem_hready, dmem_hresp}, 2'b10);
        chk("t3_w_hrdata", dmem_hrdata, 32'h0);
        chk("t3_no_second_we", ram_we, 4'h0);
        ref_mem[0][31:24] = 8'hA5;
        dmem_htrans = 2'b10; dmem_haddr = 32'h0; dmem_hsize = 3'd2;
        @(negedge clk);
        chk("t3_r_issue", {ram_en, ram_we}, 5'h10);
        dmem_htrans = 2'b00;
        @(negedge clk);
        chk("t3_r_hrdata", dmem_hrdata, ref_mem[0]);

        // Deselected transfer is ignored
        dmem_hsel = 1'b0; dmem_htrans = 2'b10; dmem_haddr = 32'h10;
        @(negedge clk);
        chk("hsel0_hready", dmem_hready, 1'b1);
        chk("hsel0_ram_en", ram_en, 1'b0);
        dmem_hsel = 1'b1; dmem_htrans = 2'b00;
        @(negedge clk);

        // Out-of-range read, then misaligned half write captured in ERR2
        dmem_htrans = 2'b10; dmem_haddr = 32'h2000; dmem_hsize = 3'd2;
        @(negedge clk);
        chk("t5a_err1", {dmem_hready, dmem_hresp, ram_en}, 3'b010);
        dmem_htrans = 2'b00;
        @(negedge clk);
        chk("t5a_err2", {dmem_hready, dmem_hresp, ram_en}, 3'b110);
        dmem_htrans = 2'b10; dmem_haddr = 32'h1; dmem_hsize = 3'd1; dmem_hwrite = 1'b1;
        @(negedge clk);
        chk("t5b_err1", {dmem_hready, dmem_hresp, ram_en}, 3'b010);
        dmem_htrans = 2'b00; dmem_hwrite = 1'b0;
        @(negedge clk);
        chk("t5b_err2", {dmem_hready, dmem_hresp, ram_en}, 3'b110);
        @(negedge clk);
        chk("t5_okay", {dmem_hready, dmem_hresp}, 2'b10);

        // Streaming on both ports, then sparse random traffic
        fork
            imem_master(40, 1'b1);
            dmem_master(40, 1'b1);
        join
        fork
            imem_master(60, 1'b0);
            dmem_master(60, 1'b0);
        join
        repeat (2) @(negedge clk);

        // Asynchronous reset while both ports are pending
        imem_htrans = 2'b10; imem_haddr = 32'h10; imem_hsize = 3'd2;
        dmem_htrans = 2'b10; dmem_haddr = 32'h20; dmem_hsize = 3'd2; dmem_hwrite = 1'b0;
        @(negedge clk);
        chk("t6_pending", {imem_hready, dmem_hready}, 2'b00);
        imem_htrans = 2'b00; dmem_htrans = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_hready", {imem_hready, dmem_hready}, 2'b11);
        chk("t6_hresp", {imem_hresp, dmem_hresp}, 2'b00);
        chk("t6_hrdata", imem_hrdata | dmem_hrdata, 32'h0);
        chk("t6_ram", {ram_en, ram_we}, 5'h0);
        @(negedge clk);
        rst_n = 1'b1;
        imem_read_t1("t6_t1");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
